// File: rtl/mul_feed_pkg.sv
// Shared types for the 8x8 multiplier feed sequencer.
package mul_feed_pkg;
    localparam int OPND_W = 8;
    localparam int PROD_W = 16;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic              clr;
    } opnd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL
    } state_t;
endpackage

// File: rtl/mul_feed_fifo.sv
// Small synchronous operand FIFO (power-of-2 depth) with full/empty/count.
module mul_feed_fifo
    import mul_feed_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  opnd_t         wdata,
    input  logic          pop,
    output opnd_t         rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    opnd_t          mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset; pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/mul_feed_seq.sv
// Feeds a free-running 9-cycle shift-add multiplier and collects its products.
// Optional MUL_FEED_ACCUM_EN: accumulate products into an ACC_W-bit register.
module mul_feed_seq
    import mul_feed_pkg::*;
#(
    parameter int MUL_PERIOD = 9,
    parameter int CAP_PH     = 0,
    parameter int IN_DEPTH   = 2,
    parameter int ACC_W      = 24,
`ifdef MUL_FEED_ACCUM_EN
    localparam int OUT_W     = ACC_W,
`else
    localparam int OUT_W     = PROD_W,
`endif
    localparam int PH_W      = $clog2(MUL_PERIOD),
    localparam int FC_W      = $clog2(IN_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
`ifdef MUL_FEED_ACCUM_EN
    input  logic              in_clr,
`endif
    output logic [OPND_W-1:0] mul_a,
    output logic [OPND_W-1:0] mul_b,
    input  logic [PROD_W-1:0] mul_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_p
);
    // Capture must land strictly between two issue edges.
    if (CAP_PH > MUL_PERIOD - 2 || ACC_W < PROD_W) begin : g_bad_cfg
        $error("mul_feed_seq: unsupported CAP_PH/MUL_PERIOD/ACC_W combination");
    end

    logic [PH_W-1:0]  ph;
    opnd_t            fifo_wr, fifo_head;
    logic             fifo_full, fifo_empty, push, issue, issue_edge, cap_edge, capture, pop_out;
    logic [FC_W-1:0]  fifo_cnt;
    logic             flag_cur, flag_prev;  // window being computed / window awaiting capture
    logic [1:0]       out_cnt;
    logic [2:0]       occ;
    logic [OUT_W-1:0] ob0, ob1, cap_val;
    state_t           state, state_nxt;

    assign issue_edge = (ph == PH_W'(MUL_PERIOD - 1));
    assign cap_edge   = (ph == PH_W'(CAP_PH));
    assign occ        = {1'b0, out_cnt} + {2'b0, flag_cur} + {2'b0, flag_prev};
    assign issue      = issue_edge && !fifo_empty && (occ < 3'd2);
    assign capture    = cap_edge && flag_prev;
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign out_valid  = (out_cnt != 2'd0);
    assign out_p      = ob0;
    assign pop_out    = out_valid && out_ready;

    assign fifo_wr.a  = in_a;
    assign fifo_wr.b  = in_b;
`ifdef MUL_FEED_ACCUM_EN
    assign fifo_wr.clr = in_clr;
`else
    logic unused_clr;
    assign fifo_wr.clr = 1'b0;
    assign unused_clr  = fifo_head.clr;
`endif

    mul_feed_fifo #(.DEPTH(IN_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wr),
        .pop   (issue),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph        <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            flag_cur  <= 1'b0;
            flag_prev <= 1'b0;
        end else begin
            ph <= issue_edge ? '0 : ph + PH_W'(1);
            if (issue_edge) begin
                mul_a     <= issue ? fifo_head.a : '0;
                mul_b     <= issue ? fifo_head.b : '0;
                flag_cur  <= issue;
                flag_prev <= flag_cur;
            end else if (capture) begin
                flag_prev <= 1'b0;
            end
        end
    end

`ifdef MUL_FEED_ACCUM_EN
    logic [OUT_W-1:0] acc;
    logic             clr_cur, clr_prev;

    assign cap_val = clr_prev ? OUT_W'(mul_o) : acc + OUT_W'(mul_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            clr_cur  <= 1'b0;
            clr_prev <= 1'b0;
        end else begin
            if (issue_edge) begin
                clr_cur  <= issue && fifo_head.clr;
                clr_prev <= clr_cur;
            end
            if (capture) acc <= cap_val;
        end
    end
`else
    assign cap_val = mul_o;
`endif

    // Two-entry output buffer; ob0 is the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob0     <= '0;
            ob1     <= '0;
            out_cnt <= 2'd0;
        end else begin
            case ({capture, pop_out})
                2'b10: begin
                    if (out_cnt == 2'd0) ob0 <= cap_val;
                    else                 ob1 <= cap_val;
                    out_cnt <= out_cnt + 2'd1;
                end
                2'b01: begin
                    ob0     <= ob1;
                    out_cnt <= out_cnt - 2'd1;
                end
                2'b11: begin
                    if (out_cnt == 2'd1) ob0 <= cap_val;
                    else begin
                        ob0 <= ob1;
                        ob1 <= cap_val;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (issue) state_nxt = ST_RUN;
            ST_RUN: begin
                if (issue_edge && !fifo_empty && !issue)
                    state_nxt = ST_STALL;
                else if (fifo_cnt == '0 && !flag_cur && !flag_prev && out_cnt == 2'd0)
                    state_nxt = ST_IDLE;
            end
            ST_STALL: if (pop_out) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mul_feed_seq.sv
// Scoreboard bench for mul_feed_seq with a behavioural 9-cycle multiplier model.
module tb_mul_feed_seq;
    localparam int P   = 9;
    localparam int CAP = 0;
`ifdef MUL_FEED_ACCUM_EN
    localparam int OW = 24;
`else
    localparam int OW = 16;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, in_clr = 1'b0, out_ready = 1'b1;
    logic [7:0]    in_a = '0, in_b = '0;
    logic [7:0]    mul_a, mul_b;
    logic [15:0]   mul_o;
    logic          in_ready, out_valid;
    logic [OW-1:0] out_p;

    always #5 clk = ~clk;

    mul_feed_seq #(.MUL_PERIOD(P), .CAP_PH(CAP), .IN_DEPTH(2), .ACC_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef MUL_FEED_ACCUM_EN
        .in_clr    (in_clr),
`endif
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_o     (mul_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    // Multiplier model: product valid only from window end until the capture edge.
    int tb_ph = 0;
    int cyc   = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_ph <= 0;
            mul_o <= '0;
        end else begin
            tb_ph <= (tb_ph == P - 1) ? 0 : tb_ph + 1;
            if (tb_ph == P - 1)    mul_o <= {8'h0, mul_a} * {8'h0, mul_b};
            else if (tb_ph == CAP) mul_o <= 16'hbeef;
        end
    end
    always @(posedge clk) cyc <= cyc + 1;

    logic [OW-1:0] exp_q[$];
    int            out_t[$];
    int            n_chk = 0, n_fail = 0, push_cyc = 0;
    logic [OW-1:0] tb_acc = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pop and compare on each output handshake; check hold under back-pressure.
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_p = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) check("out_hold", {out_valid, out_p}, {1'b1, prev_p});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_out: got %0d expected no output", out_p);
                end else begin
                    check("product", out_p, exp_q.pop_front());
                    out_t.push_back(cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_p     = out_p;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [OW-1:0] p;
        int t;
        p = OW'({8'h0, a} * {8'h0, b});
        in_a = a; in_b = b; in_clr = c; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 300) begin tick(); t++; end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stuck at 0, required 1");
            in_valid = 1'b0;
            return;
        end
`ifdef MUL_FEED_ACCUM_EN
        tb_acc = c ? p : tb_acc + p;
        exp_q.push_back(tb_acc);
`else
        exp_q.push_back(p);
`endif
        tick();
        push_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin tick(); t++; end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int t, pc, iss;
        logic ok, saw;

        // Reset state with in_valid asserted
        in_valid = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_out_p", out_p, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();

        // Single op: operands held for a whole window starting at ph 0
        out_t.delete();
        push(8'd3, 8'd5, 1'b0);
        pc = push_cyc;
        t = 0;
        while (mul_a != 8'd3 && t < 20) begin tick(); t++; end
        check("issue_ph", tb_ph, 0);
        ok = 1'b1;
        repeat (P) begin
            if (mul_a != 8'd3 || mul_b != 8'd5) ok = 1'b0;
            tick();
        end
        check("window_stable", ok, 1);
        drain();
        check("idle_mul_a", mul_a, 0);
        if (out_t.size() > 0) check("latency_ok", (out_t[0] - pc) <= 2 * P + CAP + 2, 1);
        else check("latency_out_seen", out_t.size(), 1);

        // Corner operands
        push(8'd255, 8'd255, 1'b0);
        push(8'd0, 8'd200, 1'b0);
        push(8'd1, 8'd1, 1'b0);
        drain();

        // Back-to-back: one product per window
        out_t.delete();
        push(8'd2, 8'd3, 1'b0);
        push(8'd4, 8'd5, 1'b0);
        push(8'd6, 8'd7, 1'b0);
        push(8'd8, 8'd9, 1'b0);
        drain();
        check("b2b_count", out_t.size(), 4);
        for (int i = 1; i < out_t.size(); i++) check("b2b_spacing", out_t[i] - out_t[i-1], P);

        // Back-pressure: only two windows may issue while the output is stalled
        tick();
        out_ready = 1'b0;
        saw = 1'b0;
        iss = 0;
        fork
            begin
                push(8'd3, 8'd7, 1'b0);
                push(8'd5, 8'd5, 1'b0);
                push(8'd9, 8'd9, 1'b0);
                push(8'd10, 8'd10, 1'b0);
                push(8'd12, 8'd13, 1'b0);
            end
            begin
                repeat (40) begin
                    tick();
                    if (!in_ready) saw = 1'b1;
                    if (tb_ph == 1 && mul_a != 8'd0) iss++;
                end
                check("bp_issues", iss, 2);
                check("bp_in_ready_low", saw, 1);
                check("bp_out_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-operation: buffered and in-flight products vanish
        out_ready = 1'b0;
        push(8'd2, 8'd9, 1'b0);
        push(8'd3, 8'd9, 1'b0);
        t = 0;
        while (mul_a != 8'd3 && t < 40) begin tick(); t++; end
        t = 0;
        while (tb_ph != 4 && t < 20) begin tick(); t++; end
        check("mid_ph", tb_ph, 4);
        rst_n = 1'b0;
        exp_q.delete();
        tb_acc = '0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_mul_a", mul_a, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        saw = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid) saw = 1'b1;
        end
        check("post_rst_quiet", saw, 0);
        push(8'd7, 8'd11, 1'b0);
        drain();

`ifdef MUL_FEED_ACCUM_EN
        push(8'd2, 8'd3, 1'b1);
        push(8'd4, 8'd5, 1'b0);
        drain();
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
